// File: rtl/cpu_issue_pkg.sv
// Shared issue-path types and constants for the dual-issue RV32I front end.
package cpu_issue_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h00000013;
    localparam int unsigned ISSUE_CNT_W = 2;

    typedef enum logic [ISSUE_CNT_W-1:0] {
        ISSUE_NONE = 2'd0,
        ISSUE_ONE  = 2'd1,
        ISSUE_TWO  = 2'd2
    } issue_cnt_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } issue_entry_t;

endpackage

// File: rtl/issue_queue_ctrl_if.sv
// Fetch/issue handshake bundle; master = fetch + backend side, slave = the queue.
interface issue_queue_ctrl_if
    import cpu_issue_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic                   flush;
    logic [1:0]             fetch_valid;
    logic [XLEN-1:0]        fetch_instr0;
    logic [XLEN-1:0]        fetch_instr1;
    logic [XLEN-1:0]        fetch_pc0;
    logic [XLEN-1:0]        fetch_pc1;
    logic                   fetch_ready;
    logic                   slot0_valid;
    logic                   slot1_valid;
    logic [XLEN-1:0]        slot0_instr;
    logic [XLEN-1:0]        slot1_instr;
    logic [XLEN-1:0]        slot0_pc;
    logic [XLEN-1:0]        slot1_pc;
    logic                   dual_ok;
    logic                   issue_ready;
    logic [ISSUE_CNT_W-1:0] issue_cnt;

    modport master (
        output flush, fetch_valid, fetch_instr0, fetch_instr1, fetch_pc0, fetch_pc1,
               dual_ok, issue_ready,
        input  fetch_ready, slot0_valid, slot1_valid, slot0_instr, slot1_instr,
               slot0_pc, slot1_pc, issue_cnt
    );

    modport slave (
        input  flush, fetch_valid, fetch_instr0, fetch_instr1, fetch_pc0, fetch_pc1,
               dual_ok, issue_ready,
        output fetch_ready, slot0_valid, slot1_valid, slot0_instr, slot1_instr,
               slot0_pc, slot1_pc, issue_cnt
    );
endinterface

// File: rtl/issue_queue_mem.sv
// Circular {instr,pc} storage: two write ports at ptr/ptr+1, two read ports at ptr/ptr+1.
module issue_queue_mem #(
    parameter int unsigned  DEPTH = 8,
    parameter int unsigned  XLEN  = 32,
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [PW-1:0]     wr_ptr,
    input  logic              wr_en0,
    input  logic              wr_en1,
    input  logic [2*XLEN-1:0] wr_data0,
    input  logic [2*XLEN-1:0] wr_data1,
    input  logic [PW-1:0]     rd_ptr,
    output logic [2*XLEN-1:0] rd_data0,
    output logic [2*XLEN-1:0] rd_data1
);
    logic [2*XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr1;
    logic [PW-1:0]     rd_ptr1;

    // PW-bit adds wrap modulo DEPTH because DEPTH is a power of two.
    assign wr_ptr1 = wr_ptr + PW'(1);
    assign rd_ptr1 = rd_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (wr_en0) mem[wr_ptr]  <= wr_data0;
        if (wr_en1) mem[wr_ptr1] <= wr_data1;
    end

    assign rd_data0 = mem[rd_ptr];
    assign rd_data1 = mem[rd_ptr1];
endmodule

// File: rtl/issue_queue_ctrl.sv
// Dual-issue instruction buffer: head/tail/count bookkeeping and slot muxing.
// Optional ISSUE_QUEUE_STAT_EN adds saturating dual/single/stall counters.
module issue_queue_ctrl
    import cpu_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    issue_queue_ctrl_if.slave bus
`ifdef ISSUE_QUEUE_STAT_EN
    ,
    output logic [31:0]       stat_dual,
    output logic [31:0]       stat_single,
    output logic [31:0]       stat_stall
`endif
);
    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              ready;
    logic              valid0;
    logic              valid1;
    logic              push0;
    logic              push1;
    logic [1:0]        push_n;
    issue_cnt_e        pop;
    logic [1:0]        pop_n;
    logic [2*XLEN-1:0] rd0;
    logic [2*XLEN-1:0] rd1;

    always_comb begin
        ready  = (DEPTH_C - count) >= CW'(2);
        valid0 = count != '0;
        valid1 = count >= CW'(2);
        // fetch_valid=2'b10 never pushes since slot 1 rides on slot 0.
        push0  = ready & bus.fetch_valid[0] & ~bus.flush;
        push1  = push0 & bus.fetch_valid[1];
        push_n = {1'b0, push0} + {1'b0, push1};
        if (!bus.issue_ready || !valid0 || bus.flush) pop = ISSUE_NONE;
        else if (valid1 && bus.dual_ok)              pop = ISSUE_TWO;
        else                                          pop = ISSUE_ONE;
        pop_n      = pop;
        count_next = count + CW'(push_n) - CW'(pop_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_n);
            tail  <= tail + PW'(push_n);
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !bus.flush) begin
            assert (count_next <= DEPTH_C);
            assert (CW'(pop_n) <= count);
        end
    end

    issue_queue_mem #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_mem (
        .clk      (clk),
        .wr_ptr   (tail),
        .wr_en0   (push0),
        .wr_en1   (push1),
        .wr_data0 ({bus.fetch_instr0, bus.fetch_pc0}),
        .wr_data1 ({bus.fetch_instr1, bus.fetch_pc1}),
        .rd_ptr   (head),
        .rd_data0 (rd0),
        .rd_data1 (rd1)
    );

    always_comb begin
        bus.fetch_ready = ready;
        bus.slot0_valid = valid0;
        bus.slot1_valid = valid1;
        bus.slot0_instr = valid0 ? rd0[2*XLEN-1:XLEN] : XLEN'(NOP_INSTR);
        bus.slot0_pc    = valid0 ? rd0[XLEN-1:0]      : '0;
        bus.slot1_instr = valid1 ? rd1[2*XLEN-1:XLEN] : XLEN'(NOP_INSTR);
        bus.slot1_pc    = valid1 ? rd1[XLEN-1:0]      : '0;
        bus.issue_cnt   = pop_n;
    end

`ifdef ISSUE_QUEUE_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_dual   <= '0;
            stat_single <= '0;
            stat_stall  <= '0;
        end else begin
            if (pop == ISSUE_TWO && stat_dual != '1)   stat_dual   <= stat_dual + 32'd1;
            if (pop == ISSUE_ONE && stat_single != '1) stat_single <= stat_single + 32'd1;
            if (valid0 && pop == ISSUE_NONE && !bus.flush && stat_stall != '1)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_issue_queue_ctrl.sv
// Self-checking bench for issue_queue_ctrl against a queue-based reference model.
module tb_issue_queue_ctrl;
    import cpu_issue_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    issue_queue_ctrl_if #(.XLEN(32)) bus ();

`ifdef ISSUE_QUEUE_STAT_EN
    logic [31:0] stat_dual, stat_single, stat_stall;
    int unsigned m_dual, m_single, m_stall;
`endif

    issue_queue_ctrl #(
        .DEPTH (DEPTH),
        .XLEN  (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ISSUE_QUEUE_STAT_EN
        ,
        .stat_dual   (stat_dual),
        .stat_single (stat_single),
        .stat_stall  (stat_stall)
`endif
    );

    issue_entry_t q[$];
    int unsigned  total = 0;
    int unsigned  bad   = 0;
    logic [31:0]  next_pc = 32'h0000_1000;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int model_cnt();
        if (bus.flush || !bus.issue_ready || q.size() == 0) return 0;
        if (q.size() >= 2 && bus.dual_ok) return 2;
        return 1;
    endfunction

    task automatic check_outputs();
        int n = q.size();
        chk("fetch_ready", 64'(bus.fetch_ready), 64'((DEPTH - n) >= 2));
        chk("slot0_valid", 64'(bus.slot0_valid), 64'(n >= 1));
        chk("slot1_valid", 64'(bus.slot1_valid), 64'(n >= 2));
        chk("slot0_instr", 64'(bus.slot0_instr), 64'(n >= 1 ? q[0].instr : NOP_INSTR));
        chk("slot0_pc",    64'(bus.slot0_pc),    64'(n >= 1 ? q[0].pc : 32'h0));
        chk("slot1_instr", 64'(bus.slot1_instr), 64'(n >= 2 ? q[1].instr : NOP_INSTR));
        chk("slot1_pc",    64'(bus.slot1_pc),    64'(n >= 2 ? q[1].pc : 32'h0));
        chk("issue_cnt",   64'(bus.issue_cnt),   64'(model_cnt()));
`ifdef ISSUE_QUEUE_STAT_EN
        chk("stat_dual",   64'(stat_dual),   64'(m_dual));
        chk("stat_single", 64'(stat_single), 64'(m_single));
        chk("stat_stall",  64'(stat_stall),  64'(m_stall));
`endif
    endtask

    task automatic update_model();
        int  cnt   = model_cnt();
        bit  ready = (DEPTH - q.size()) >= 2;
`ifdef ISSUE_QUEUE_STAT_EN
        if (cnt == 2) m_dual++;
        if (cnt == 1) m_single++;
        if (q.size() > 0 && cnt == 0 && !bus.flush) m_stall++;
`endif
        if (bus.flush) begin
            q.delete();
            return;
        end
        repeat (cnt) void'(q.pop_front());
        if (ready && bus.fetch_valid[0]) begin
            q.push_back('{instr: bus.fetch_instr0, pc: bus.fetch_pc0});
            if (bus.fetch_valid[1]) q.push_back('{instr: bus.fetch_instr1, pc: bus.fetch_pc1});
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic drive(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1,
                         input logic dok, input logic ird, input logic fl);
        bus.fetch_valid  = fv;
        bus.fetch_instr0 = i0;
        bus.fetch_pc0    = p0;
        bus.fetch_instr1 = i1;
        bus.fetch_pc1    = p1;
        bus.dual_ok      = dok;
        bus.issue_ready  = ird;
        bus.flush        = fl;
    endtask

    task automatic rand_drive(input bit allow_flush);
        drive(2'($urandom_range(0, 3)), $urandom, next_pc, $urandom, next_pc + 32'd4,
              1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
              allow_flush && ($urandom_range(0, 15) == 0));
        next_pc += 32'd8;
    endtask

    task automatic idle();
        drive(2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
`ifdef ISSUE_QUEUE_STAT_EN
        m_dual = 0; m_single = 0; m_stall = 0;
`endif
        #2;
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Dual issue
        drive(2'b11, 32'h00500093, 32'h0, 32'h00308113, 32'h4, 1'b0, 1'b0, 1'b0); cycle();
        drive(2'b00, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0); cycle();
        cycle();

        // Serial issue
        drive(2'b11, 32'h00500093, 32'h0, 32'h00308113, 32'h4, 1'b0, 1'b0, 1'b0); cycle();
        drive(2'b00, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0); cycle();
        cycle();
        cycle();

        // Fill to DEPTH-1, then pop one while a pair is offered
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, $urandom, next_pc, $urandom, next_pc + 32'd4, 1'b0, 1'b0, 1'b0);
            next_pc += 32'd8;
            cycle();
        end
        drive(2'b01, $urandom, next_pc, '0, '0, 1'b0, 1'b0, 1'b0); next_pc += 32'd8; cycle();
        drive(2'b11, $urandom, next_pc, $urandom, next_pc + 32'd4, 1'b0, 1'b1, 1'b0); cycle();
        idle(); cycle();
        chk("count_after_full_pop", 64'(q.size()), 64'(DEPTH - 2));

        // Flush with five entries held
        drive(2'b00, '0, '0, '0, '0, 1'b0, 1'b1, 1'b1); cycle();
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, $urandom, next_pc, $urandom, next_pc + 32'd4, 1'b0, 1'b0, 1'b0);
            next_pc += 32'd8;
            cycle();
        end
        drive(2'b01, $urandom, next_pc, '0, '0, 1'b0, 1'b0, 1'b0); next_pc += 32'd8; cycle();
        chk("pre_flush_count", 64'(q.size()), 64'd5);
        drive(2'b11, $urandom, next_pc, $urandom, next_pc + 32'd4, 1'b1, 1'b1, 1'b1); cycle();
        idle(); cycle();

        // Walk tail to DEPTH-1, then push a pair across the wrap
        for (int i = 0; i < 7; i++) begin
            drive(2'b01, $urandom, next_pc, '0, '0, 1'b0, 1'b1, 1'b0);
            next_pc += 32'd8;
            cycle();
        end
        drive(2'b11, $urandom, next_pc, $urandom, next_pc + 32'd4, 1'b0, 1'b0, 1'b0);
        next_pc += 32'd8;
        cycle();
        for (int i = 0; i < 20; i++) begin
            rand_drive(1'b0);
            cycle();
        end

        // Longer random traffic including flushes
        for (int i = 0; i < 300; i++) begin
            rand_drive(1'b1);
            cycle();
        end

        // Asynchronous reset mid-traffic
        rand_drive(1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        q.delete();
`ifdef ISSUE_QUEUE_STAT_EN
        m_dual = 0; m_single = 0; m_stall = 0;
`endif
        check_outputs();
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
